// File: rtl/line_buffer_pkg.sv
// Shared types and helpers for the rotating-row line buffer controller.
package line_buffer_pkg;

  typedef enum logic [1:0] {LB_IDLE, LB_FILL, LB_STREAM, LB_DONE} lb_state_t;

  localparam int LB_MAX_BANKS = 16;

  // Rotate a one-hot bank select left by one within the low n bits.
  function automatic logic [LB_MAX_BANKS-1:0] rotl_onehot(
    input logic [LB_MAX_BANKS-1:0] v,
    input int                      n
  );
    logic [LB_MAX_BANKS-1:0] top;
    top = LB_MAX_BANKS'(1) << (n - 1);
    if ((v & top) != '0) return LB_MAX_BANKS'(1);
    return v << 1;
  endfunction

endpackage

// File: rtl/line_buffer_ctrl.sv
// Write/read controller for the rotating-row line buffer: writes each row into
// the next bank and reads the others at the same column.
module line_buffer_ctrl
  import line_buffer_pkg::*;
#(
  parameter int KER_SIZE = 3,
  parameter int DW       = 32,
  parameter int NW       = 32,
  parameter int AW       = $clog2(NW),
  parameter int HW       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW:0]         img_width,
  input  logic [HW-1:0]       img_height,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  output logic [AW-1:0]       a,
  output logic [KER_SIZE:0]   wen,
  output logic [KER_SIZE:0]   ren,
  output logic [DW-1:0]       d,
  output logic                out_valid,
  output logic [AW-1:0]       out_col,
  output logic [HW-1:0]       out_row,
  output logic                frame_done,
  output logic                busy
);

  localparam int NB = KER_SIZE + 1;

  lb_state_t       state, state_nx;
  logic [AW-1:0]   col;
  logic [HW-1:0]   row;
  logic [NB-1:0]   wr_bank;
  logic [AW:0]     width_q;
  logic [HW-1:0]   height_q;
  logic            accept, start_ok, col_last, row_last, row_done, streaming;

  assign in_ready   = (state == LB_FILL) || (state == LB_STREAM);
  assign busy       = (state != LB_IDLE);
  assign frame_done = (state == LB_DONE);
  assign streaming  = (state == LB_STREAM);
  assign accept     = in_valid & in_ready;
  assign start_ok   = start && (img_width != '0) && (img_width <= (AW+1)'(NW));
  assign col_last   = ({1'b0, col} == width_q - (AW+1)'(1));
  assign row_last   = (row == height_q - HW'(1));
  assign row_done   = accept & col_last;

  always_ff @(posedge clk) begin
    if (rst) state <= LB_IDLE;
    else     state <= state_nx;
  end

  // Array ports are combinational; the array registers them internally.
  always_comb begin
    state_nx = state;
    a   = '0;
    d   = '0;
    wen = '0;
    ren = '0;
    case (state)
      LB_IDLE:   if (start_ok) state_nx = LB_FILL;
      LB_FILL:   if (row_done) begin
                   if (row_last)                        state_nx = LB_DONE;
                   else if (row == HW'(KER_SIZE - 1))   state_nx = LB_STREAM;
                 end
      LB_STREAM: if (row_done && row_last) state_nx = LB_DONE;
      LB_DONE:   state_nx = LB_IDLE;
      default:   state_nx = LB_IDLE;
    endcase
    if (accept) begin
      a   = col;
      d   = in_data;
      wen = wr_bank;
      if (streaming) ren = ~wr_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      wr_bank   <= NB'(1);
      width_q   <= '0;
      height_q  <= '0;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_row   <= '0;
    end else begin
      out_valid <= accept && streaming;
      if (accept && streaming) begin
        out_col <= col;
        out_row <= row;
      end
      if (state == LB_IDLE && start_ok) begin
        col      <= '0;
        row      <= '0;
        wr_bank  <= NB'(1);
        width_q  <= img_width;
        height_q <= img_height;
      end else if (accept) begin
        if (col_last) begin
          col     <= '0;
          row     <= row + HW'(1);
          wr_bank <= NB'(rotl_onehot(LB_MAX_BANKS'(wr_bank), NB));
        end else begin
          col <= col + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: scenario table plus per-cycle comparison against
// a pixel-count model of the frame.
module tb_line_buffer_ctrl;

  localparam int K  = 3;
  localparam int DW = 32;
  localparam int NW = 32;
  localparam int AW = 5;
  localparam int HW = 16;
  localparam int NB = K + 1;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready;
  logic [AW:0]   img_width;
  logic [HW-1:0] img_height;
  logic [DW-1:0] in_data, d;
  logic [AW-1:0] a, out_col;
  logic [K:0]    wen, ren;
  logic          out_valid, frame_done, busy;
  logic [HW-1:0] out_row;

  line_buffer_ctrl #(.KER_SIZE(K), .DW(DW), .NW(NW), .AW(AW), .HW(HW)) dut (
    .clk(clk), .rst(rst), .start(start), .img_width(img_width), .img_height(img_height),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .a(a), .wen(wen),
    .ren(ren), .d(d), .out_valid(out_valid), .out_col(out_col), .out_row(out_row),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // Model: a frame is W*H pixels; pixel k sits at row k/W, col k%W.
  int m_active = 0, m_done = 0, m_busy = 0, m_ov = 0, m_ocol = 0, m_orow = 0;
  int m_k = 0, m_W = 0, m_H = 0, m_after_rst = 0;
  int dut_beats, dut_acc, dut_dones;

  typedef struct {
    int w, h, mode, mid;
    int exp_beats, exp_acc, exp_done;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    int r, c, acc, ew, er;
    @(negedge clk);
    r   = (m_W > 0) ? m_k / m_W : 0;
    c   = (m_W > 0) ? m_k % m_W : 0;
    acc = m_active && in_valid;
    ew  = acc ? (1 << (r % NB)) : 0;
    er  = (acc && r >= K) ? (~ew & ((1 << NB) - 1)) : 0;
    chk("in_ready", in_ready, m_active);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_done);
    chk("out_valid", out_valid, m_ov);
    chk("wen", wen, ew);
    chk("ren", ren, er);
    chk("a", a, acc ? c : 0);
    chk("d", d, acc ? in_data : 0);
    if (m_ov || m_after_rst) begin
      chk("out_col", out_col, m_after_rst ? 0 : m_ocol);
      chk("out_row", out_row, m_after_rst ? 0 : m_orow);
    end
    if (out_valid) dut_beats++;
    if (frame_done) dut_dones++;
    if (in_valid && in_ready) dut_acc++;
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_done = 0; m_busy = 0; m_ov = 0; m_k = 0; m_after_rst = 1;
    end else begin
      int idle;
      m_after_rst = 0;
      idle = !m_active && !m_done;
      m_ov = acc && (r >= K);
      if (m_ov) begin m_ocol = c; m_orow = r; end
      m_done = acc && (m_k == m_W * m_H - 1);
      if (acc) begin
        m_k++;
        if (m_k == m_W * m_H) m_active = 0;
      end
      if (idle && start && img_width >= 1 && img_width <= NW) begin
        m_active = 1; m_k = 0; m_W = int'(img_width); m_H = int'(img_height);
      end
      m_busy = m_active || m_done;
    end
    #1;
  endtask

  task automatic set_pix(input int mode, input int cyc);
    case (mode)
      0:       in_valid = 1'b1;
      1:       in_valid = (cyc % 2 == 0);
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    if (mode == 2 || m_W == 0) in_data = $urandom;
    else in_data = DW'((m_k / m_W) * 16 + (m_k % m_W));
  endtask

  task automatic run_frame(input int w, input int h, input int mode, input int mid);
    int cyc = 0, mid_done = 0;
    dut_beats = 0; dut_acc = 0; dut_dones = 0;
    img_width = (AW+1)'(w); img_height = HW'(h);
    start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
    while ((m_active || m_busy) && cyc < 1000) begin
      set_pix(mode, cyc);
      if (mid && !mid_done && m_k == K * m_W + 1) begin
        start = 1'b1; img_width = 1; img_height = 1; mid_done = 1;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 1000) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: frame w=%0d h=%0d still busy after %0d cycles", w, h, cyc);
    end
    in_valid = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    tbl[0] = '{4, 5, 0, 0,  8,  20, 1};
    tbl[1] = '{2, 6, 0, 0,  6,  12, 1};
    tbl[2] = '{4, 5, 1, 0,  8,  20, 1};
    tbl[3] = '{4, 2, 0, 0,  0,   8, 1};
    tbl[4] = '{0, 5, 0, 0,  0,   0, 0};
    tbl[5] = '{33, 5, 0, 0, 0,   0, 0};
    tbl[6] = '{4, 5, 0, 1,  8,  20, 1};
    tbl[7] = '{1, 1, 0, 0,  0,   1, 1};
    tbl[8] = '{32, 4, 2, 0, 32, 128, 1};
    tbl[9] = '{3, 7, 2, 0, 12,  21, 1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = $urandom;
    img_width = 4; img_height = 5;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_frame(tbl[i].w, tbl[i].h, tbl[i].mode, tbl[i].mid);
      chk($sformatf("beats[%0d]", i), dut_beats, tbl[i].exp_beats);
      chk($sformatf("accepts[%0d]", i), dut_acc, tbl[i].exp_acc);
      chk($sformatf("dones[%0d]", i), dut_dones, tbl[i].exp_done);
    end

    // Reset while row 3 col 1 is being accepted, then a clean frame.
    dut_dones = 0;
    img_width = 4; img_height = 5; start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && m_k != 13; cyc++) begin
      set_pix(0, cyc);
      tick();
    end
    chk("mid_rst_pos", m_k, 13);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_rst_no_done", dut_dones, 0);
    run_frame(4, 5, 0, 0);
    chk("post_rst_beats", dut_beats, 8);
    chk("post_rst_accepts", dut_acc, 20);
    chk("post_rst_dones", dut_dones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Write/read controller for the rotating-row line buffer (`sram_array_k2/k3/k5`) in the convolution datapath. It accepts a raster-order pixel stream and writes each image row into the next of `KER_SIZE+1` row banks. Banks are used in round-robin. On every write it reads the other banks at the same column address. It flags, one cycle later, when the array's `q` output holds a valid `KER_SIZE`-row column for the downstream MAC stage.

## Interface
- `KER_SIZE`, 3: kernel height; the number of banks is `KER_SIZE+1`.
- `DW`, 32: pixel width.
- `NW`, 32: maximum image width, equal to the bank depth.
- `AW`, `$clog2(NW)`: column address width.
- `HW`, 16: row counter width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that latches the frame geometry. Accepted only in IDLE.
- `img_width` in AW+1: columns per row. Legal range is 1..NW.
- `img_height` in HW: rows per frame. Legal range is ≥1.
- `in_valid` in 1: pixel available.
- `in_ready` out 1: controller accepts a pixel.
- `in_data` in DW: pixel value.
- `a` out AW: bank address, driven to the array.
- `wen` out KER_SIZE+1: one-hot write enable per bank.
- `ren` out KER_SIZE+1: read enables, the complement of `wen` while reading.
- `d` out DW: write data, equal to `in_data`.
- `out_valid` out 1: the array `q` holds a valid window column in this cycle.
- `out_col` out AW: column index of the `q` data.
- `out_row` out HW: index of the newest row in the window.
- `frame_done` out 1: one-cycle pulse after the last pixel of the frame.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **States.**
  - IDLE: `in_ready=0`.
  - FILL: the first `KER_SIZE` rows are written. No window exists yet.
  - STREAM: rows `KER_SIZE..img_height-1`.
  - DONE: lasts one cycle and pulses `frame_done`.
- **Transitions.**
  - IDLE→FILL on a `start` with legal geometry. `start` with `img_width==0` or `img_width>NW` is ignored.
  - FILL→STREAM when row `KER_SIZE-1` completes.
  - FILL→DONE if `img_height≤KER_SIZE` and the last row completes.
  - STREAM→DONE when row `img_height-1` completes.
  - DONE→IDLE unconditionally.
  - `start` outside IDLE is ignored.
- **Accept rule.** A pixel is accepted when `in_valid & in_ready`. `in_ready=1` in FILL and STREAM.
- **Accept cycle actions.** In the accept cycle:
  - `a = col`.
  - `wen` = one-hot `wr_bank`.
  - `ren = ~wen` in STREAM only. In FILL, `ren=0`.
  - `d = in_data`.
- **Non-accept cycles.** `wen=0` and `ren=0`, so the array holds `q`.
- **Column counter** `col`: 0..`img_width-1`. It increments per accepted pixel and wraps to 0 at row end.
- **Row end.** At row end `row` increments. `wr_bank` rotates left by one, from bit `KER_SIZE` wrapping to bit 0.
- **Reset values.** `wr_bank` resets to bit 0 and is re-initialised to bit 0 on each accepted `start`.
- **Row ordering.** The array reorders rows using its own delayed `wen`. This block does not reorder data.
- **Input backpressure.** Downstream must consume every `out_valid` beat. The only backpressure is `in_valid`.
- **Arithmetic.** Counters are unsigned. `row` is compared with `img_height-1` at full HW width, with no overflow because `img_height ≤ 2^HW-1`. Geometry is latched at `start` and is stable for the whole frame.

## Timing
- Synchronous reset results, in the cycle after `rst` is sampled high:
  - State is IDLE.
  - `in_ready`, `wen`, `ren`, `out_valid`, `frame_done` and `busy` are 0.
  - `a`, `d`, `out_col` and `out_row` are 0.
  - `col=0`, `row=0`.
- Reset mid-frame aborts the frame with no `frame_done`. Bank contents are don't-care.
- **Output latency.** 1 cycle, matching the array read latency. `out_valid`, `out_col` and `out_row` are registered copies of the STREAM accept cycle's `ren!=0`, `col` and `row`.
- **Output throughput.** One window column per cycle at full input rate. Gaps in `in_valid` produce equal gaps in `out_valid`.
- **frame_done timing.** `frame_done` is asserted in the cycle after the final accept, coincident with the last `out_valid`. `busy` falls one cycle later.
- **Back-to-back frames.** A new `start` is accepted no earlier than the cycle after DONE.
- **Registered outputs.** `wen`, `ren`, `a` and `d` are combinational from the accept condition and registered state, because the array registers them internally. All other outputs are registered.

## Structure
- **Package `line_buffer_pkg`.**
  - `typedef enum logic [1:0] {LB_IDLE, LB_FILL, LB_STREAM, LB_DONE} lb_state_t`.
  - Function `rotl_onehot` for bank rotation.
- **Single module.** Counters, FSM and output registers are inline. No sub-module is warranted.
- **Array instance.** The array is instantiated alongside this block by the parent, not inside it.

## Test plan
All scenarios use KER_SIZE=3.
1. **Basic frame.** Reset, then `start` with width=4, height=5, and continuous `in_valid`, data = `row*16+col`.
   - FILL lasts 12 cycles.
   - There are 8 `out_valid` beats, with `out_row` 3,3,3,3,4,4,4,4 and `out_col` 0..3.
   - At row 4 col 2, `q` = {0x22,0x32,0x42}.
   - `frame_done` is asserted once.
2. **Bank rotation.** Width=2, height=6. `wen` sequence per row is 0001,0010,0100,1000,0001,0010.
   - `ren` is the complement from row 3 onward and 0000 before that.
3. **Input stalls.** Toggle `in_valid` 1010… on scenario 1.
   - `out_valid` beats equal the accepted STREAM pixels, each exactly 1 cycle after its accept.
   - Data and indices are the same as scenario 1.
4. **Short frame.** Height=2.
   - Exactly 0 `out_valid` beats.
   - `frame_done` follows the 8th accept.
5. **Illegal or busy start.**
   - `start` with width=0 or width=NW+1: the block stays IDLE.
   - `start` during STREAM: ignored, and the frame is unaffected.
6. **Reset mid-frame.** Assert `rst` during row 3 col 1.
   - The next cycle shows IDLE with all outputs 0 and no `frame_done`.
   - A fresh frame afterwards matches scenario 1.
